// File: rtl/memory_arbiter_pkg.sv
// Shared types for the I/D memory arbiter: RAM handshake state, word type and FSM states.
package memory_arbiter_pkg;

  localparam int WORD_W_DEF = 32;

  typedef logic [WORD_W_DEF-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// CPU-side requester signals and RAM-side port of the arbiter, bundled as one interface.
interface memory_arbiter_if #(
  parameter int WORD_W = 32
);
  import memory_arbiter_pkg::*;

  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;

  logic              mem_err;

  // Arbiter side
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  // CPU + RAM side
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

endinterface

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data access, one transaction at a time,
// with a bounded run of data grants so fetch cannot starve.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int DSTREAK_MAX = 4
) (
  input logic              CLK,
  input logic              nRST,
  memory_arbiter_if.slave  bus
);

  localparam int SW = $clog2(DSTREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DSTREAK_MAX);

  arb_state_t    state;
  logic [SW-1:0] dstreak;
  logic          d_pend;
  logic          i_live;
  logic          d_live;

  assign d_pend = bus.dREN | bus.dWEN;
  assign i_live = (state == IGRANT) && bus.iREN;
  assign d_live = (state == DGRANT) && d_pend;

  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

  always_comb begin
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.mem_err  = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state)
      IGRANT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
      end
      DGRANT: begin
        // a write takes precedence when both read and write are requested
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dWEN ? bus.dstore : '0;
      end
      default: ;
    endcase
    if (bus.ramstate == ACCESS) begin
      bus.iwait = ~i_live;
      bus.dwait = ~d_live;
    end
    bus.mem_err = (i_live | d_live) && (bus.ramstate == ERROR);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      dstreak <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_pend && !(bus.iREN && dstreak == STREAK_MAX)) state <= DGRANT;
          else if (bus.iREN)                                  state <= IGRANT;
        end
        IGRANT: begin
          if (!bus.iREN) begin
            state <= IDLE;
          end else if (bus.ramstate == ACCESS) begin
            state   <= IDLE;
            dstreak <= '0;
          end else if (bus.ramstate == ERROR) begin
            state <= IDLE;
          end
        end
        DGRANT: begin
          if (!d_pend) begin
            state <= IDLE;
          end else if (bus.ramstate == ACCESS) begin
            state <= IDLE;
            if (dstreak != STREAK_MAX) dstreak <= dstreak + 1'b1;
          end else if (bus.ramstate == ERROR) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: scripted RAM responder, expected acks queued at request time.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic nRST;

  memory_arbiter_if #(.WORD_W(32)) bus ();

  memory_arbiter #(.WORD_W(32), .DSTREAK_MAX(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  exp_t        sb[$];
  int          checks    = 0;
  int          passed    = 0;
  int          busy_cfg  = 0;
  int          busy_left = 0;
  logic        err_next  = 1'b0;
  logic [31:0] load_val  = 32'h0;
  logic        i_hold    = 1'b0;
  logic        d_hold    = 1'b0;
  int          i_acks    = 0;
  int          d_acks    = 0;
  int          err_cnt   = 0;
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  int          d_before  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic set_ram(input int busy, input logic err);
    busy_cfg  = busy;
    busy_left = busy;
    err_next  = err;
  endtask

  // One clock: answer the RAM drive, then score any ack against the queue.
  task automatic cycle();
    exp_t e;
    @(posedge CLK);
    #1;
    if (bus.ramREN || bus.ramWEN) begin
      if (bus.ramREN) rd_cycles++;
      if (bus.ramWEN) wr_cycles++;
      if (busy_left > 0) begin
        bus.ramstate = BUSY;
        busy_left--;
      end else begin
        bus.ramstate = err_next ? ERROR : ACCESS;
        busy_left    = busy_cfg;
      end
    end else begin
      bus.ramstate = FREE;
      busy_left    = busy_cfg;
    end
    bus.ramload = load_val;
    #1;
    if (bus.mem_err === 1'b1) err_cnt++;
    if (bus.iwait === 1'b0) begin
      i_acks++;
      chk1("i_ack_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk1("i_ack_kind", 1'b0, e.is_d);
        chk("i_ack_addr", bus.ramaddr, e.addr);
        chk("i_ack_load", bus.iload, e.data);
      end
      if (!i_hold) bus.iREN = 1'b0;
    end
    if (bus.dwait === 1'b0) begin
      d_acks++;
      chk1("d_ack_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk1("d_ack_kind", 1'b1, e.is_d);
        chk("d_ack_addr", bus.ramaddr, e.addr);
        if (e.wr) begin
          chk1("d_wr_ramWEN", bus.ramWEN, 1'b1);
          chk1("d_wr_ramREN", bus.ramREN, 1'b0);
          chk("d_wr_ramstore", bus.ramstore, e.data);
        end else begin
          chk1("d_rd_ramREN", bus.ramREN, 1'b1);
          chk("d_rd_load", bus.dload, e.data);
        end
      end
      if (!d_hold) begin
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
      end
    end
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    nRST         = 1'b0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramstate = FREE;
    bus.ramload  = 32'h5A5A_C3C3;
    #2;
    chk1("rst_ramREN", bus.ramREN, 1'b0);
    chk1("rst_ramWEN", bus.ramWEN, 1'b0);
    chk("rst_ramaddr", bus.ramaddr, 32'h0);
    chk("rst_ramstore", bus.ramstore, 32'h0);
    chk1("rst_iwait", bus.iwait, 1'b1);
    chk1("rst_dwait", bus.dwait, 1'b1);
    chk1("rst_mem_err", bus.mem_err, 1'b0);
    chk("rst_iload", bus.iload, 32'h5A5A_C3C3);
    chk("rst_dload", bus.dload, 32'h5A5A_C3C3);
    @(negedge CLK);
    nRST = 1'b1;

    // reset while a write is stalled on BUSY
    set_ram(50, 1'b0);
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h40;
    bus.dstore = 32'hCAFE_0001;
    cycle();
    chk1("dg_ramWEN", bus.ramWEN, 1'b1);
    chk("dg_ramaddr", bus.ramaddr, 32'h40);
    chk1("dg_dwait_busy", bus.dwait, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    chk1("rst_mid_ramWEN", bus.ramWEN, 1'b0);
    chk1("rst_mid_dwait", bus.dwait, 1'b1);
    chk("rst_mid_ramaddr", bus.ramaddr, 32'h0);
    bus.dWEN     = 1'b0;
    bus.ramstate = FREE;
    #3;
    nRST = 1'b1;
    cycle();
    chk1("post_rst_ramREN", bus.ramREN, 1'b0);
    chk1("post_rst_ramWEN", bus.ramWEN, 1'b0);

    // lone instruction read, two BUSY cycles
    set_ram(2, 1'b0);
    load_val  = 32'hDEAD_BEEF;
    rd_cycles = 0;
    i_acks    = 0;
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h100;
    sb.push_back('{1'b0, 1'b0, 32'h100, 32'hDEAD_BEEF});
    run(20);
    repeat (3) cycle();
    chk("i_read_drive_cycles", rd_cycles, 3);
    chk("i_read_ack_count", i_acks, 1);

    // simultaneous requests: data first, then fetch
    set_ram(0, 1'b0);
    load_val  = 32'h1111_2222;
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h200;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h300;
    sb.push_back('{1'b1, 1'b0, 32'h300, 32'h1111_2222});
    sb.push_back('{1'b0, 1'b0, 32'h200, 32'h1111_2222});
    run(20);

    // starvation bound: four data grants, one fetch, then data again
    set_ram(0, 1'b0);
    load_val  = 32'h0BAD_F00D;
    i_hold    = 1'b1;
    d_hold    = 1'b1;
    i_acks    = 0;
    d_acks    = 0;
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h600;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h500;
    for (int k = 0; k < 4; k++) sb.push_back('{1'b1, 1'b0, 32'h500, 32'h0BAD_F00D});
    sb.push_back('{1'b0, 1'b0, 32'h600, 32'h0BAD_F00D});
    sb.push_back('{1'b1, 1'b0, 32'h500, 32'h0BAD_F00D});
    run(60);
    i_hold   = 1'b0;
    d_hold   = 1'b0;
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    repeat (2) cycle();
    chk("starve_d_acks", d_acks, 5);
    chk("starve_i_acks", i_acks, 1);

    // write wins over read
    set_ram(1, 1'b0);
    rd_cycles  = 0;
    wr_cycles  = 0;
    bus.dREN   = 1'b1;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h700;
    bus.dstore = 32'h1234_5678;
    sb.push_back('{1'b1, 1'b1, 32'h700, 32'h1234_5678});
    run(20);
    chk("wr_read_cycles", rd_cycles, 0);
    chk("wr_write_cycles", wr_cycles, 2);

    // fetch withdrawn while RAM is still busy
    set_ram(3, 1'b0);
    i_acks    = 0;
    bus.iREN  = 1'b1;
    bus.iaddr = 32'hA00;
    cycle();
    cycle();
    chk1("drop_ramREN_held", bus.ramREN, 1'b1);
    chk("drop_ramaddr_held", bus.ramaddr, 32'hA00);
    bus.iREN = 1'b0;
    cycle();
    chk1("drop_ramREN_idle", bus.ramREN, 1'b0);
    cycle();
    chk("drop_no_ack", i_acks, 0);

    // fetch ends in ERROR; pending data is granted right after
    set_ram(0, 1'b1);
    err_cnt   = 0;
    bus.iREN  = 1'b1;
    bus.iaddr = 32'hB00;
    cycle();
    chk1("err_mem_err", bus.mem_err, 1'b1);
    chk1("err_iwait", bus.iwait, 1'b1);
    err_next  = 1'b0;
    load_val  = 32'h7777_0000;
    bus.dREN  = 1'b1;
    bus.daddr = 32'hC00;
    sb.push_back('{1'b1, 1'b0, 32'hC00, 32'h7777_0000});
    sb.push_back('{1'b0, 1'b0, 32'hB00, 32'h7777_0000});
    cycle();
    chk1("err_pulse_gone", bus.mem_err, 1'b0);
    chk1("err_idle_ramREN", bus.ramREN, 1'b0);
    d_before = d_acks;
    cycle();
    chk("err_then_d_grant", d_acks, d_before + 1);
    run(20);
    chk("err_pulse_count", err_cnt, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
